// File: rtl/gpr_pkg.sv
// Shared constants and helpers for the GPR read-port arbiter.
// No logic or latency of its own.
// No backpressure; holds only types, constants and functions.
package gpr_pkg;

  localparam int GPR_AW   = 4;
  localparam int GPR_DW   = 16;
  localparam int GPR_NREG = 16;
  localparam int MAX_REQ  = 8;

  // One-hot encode a requester index (up to MAX_REQ requesters)
  function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/gpr_rd_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo NREQ.
// Purely combinational, zero latency.
// No backpressure; the caller decides whether the pick becomes a grant.
module rr_pick
  import gpr_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   win_o,
  output logic            any_o
);

  int                 base;
  int                 cand;
  logic [MAX_REQ-1:0] oh;

  // Scan from the pointer; an out-of-range pointer restarts the search at 0
  always_comb begin
    base  = (int'(ptr_i) < NREQ) ? int'(ptr_i) : 0;
    cand  = 0;
    any_o = 1'b0;
    win_o = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = base + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        win_o = PW'(cand);
      end
    end
    oh    = onehot(3'(win_o));
    gnt_o = any_o ? oh[NREQ-1:0] : '0;
  end

endmodule

// File: rtl/gpr_rd_arbiter.sv
// Shares the single register-file read port among NREQ requesters, round-robin.
// Grant/RSEL combinational in cycle t; RVALID/RDATA registered, valid in t+1.
// HOLD or reset suppresses all grants; requesters keep REQ/ADDR until granted.
module gpr_rd_arbiter
  import gpr_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int BYPASS = 1
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NREQ-1:0]        REQ,
  input  logic [GPR_AW*NREQ-1:0] ADDR,
  input  logic                   HOLD,
  output logic [NREQ-1:0]        GNT,
  output logic [GPR_AW-1:0]      RSEL,
  input  logic [GPR_DW-1:0]      RDATA_IN,
  input  logic                   WE,
  input  logic [GPR_AW-1:0]      WADDR,
  input  logic [GPR_DW-1:0]      WDATA,
  output logic [NREQ-1:0]        RVALID,
  output logic [GPR_DW-1:0]      RDATA
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0]     ptr_q,    ptr_d;
  logic [NREQ-1:0]   rvalid_q, rvalid_d;
  logic [GPR_DW-1:0] rdata_q,  rdata_d;

  logic [NREQ-1:0]   pick_gnt;
  logic [PW-1:0]     win;
  logic              pick_any;
  logic              grant;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req_i (REQ),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .win_o (win),
    .any_o (pick_any)
  );

  // A pick only becomes a grant outside reset and HOLD
  assign grant = !RST && !HOLD && pick_any;

  // Drive grant and read-mux select; both idle at zero when nothing is granted
  always_comb begin
    GNT  = '0;
    RSEL = '0;
    if (grant) begin
      GNT  = pick_gnt;
      RSEL = ADDR[GPR_AW*int'(win) +: GPR_AW];
    end
  end

  // Next state: capture read data (forwarding a coincident write if enabled)
  always_comb begin
    ptr_d    = ptr_q;
    rvalid_d = '0;
    rdata_d  = rdata_q;
    if (grant) begin
      rvalid_d = pick_gnt;
      ptr_d    = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
      if ((BYPASS != 0) && WE && (WADDR == RSEL)) rdata_d = WDATA;
      else                                        rdata_d = RDATA_IN;
    end
  end

  // State registers; reset discards any grant pending in the same cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q    <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign RVALID = rvalid_q;
  assign RDATA  = rdata_q;

endmodule

// File: tb/tb_gpr_rd_arbiter.sv
// Directed bench for gpr_rd_arbiter with NREQ=4; one instance per BYPASS setting.
// Inputs change on the falling edge; combinational outputs checked 1ns later,
// registered outputs checked 1ns after the rising edge.
module tb_gpr_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] addr;
  logic        hold;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;

  logic [3:0]  gnt0, rsel0, rvalid0;
  logic [15:0] rdata0, rdata_in0;
  logic [3:0]  gnt1, rsel1, rvalid1;
  logic [15:0] rdata1, rdata_in1;

  logic [15:0] regs [16];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int i);
    if (i == 3) return 16'h0000;
    if (i == 9) return 16'hBEEF;
    return 16'hA000 + 16'(i);
  endfunction

  // Register file model: loaded during reset, written at the rising edge
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) regs[i] <= init_val(i);
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_in0 = regs[rsel0];
  assign rdata_in1 = regs[rsel1];

  gpr_rd_arbiter #(.NREQ(4), .BYPASS(1)) dut0 (
    .CLK(clk), .RST(rst), .REQ(req), .ADDR(addr), .HOLD(hold),
    .GNT(gnt0), .RSEL(rsel0), .RDATA_IN(rdata_in0),
    .WE(we), .WADDR(waddr), .WDATA(wdata),
    .RVALID(rvalid0), .RDATA(rdata0)
  );

  gpr_rd_arbiter #(.NREQ(4), .BYPASS(0)) dut1 (
    .CLK(clk), .RST(rst), .REQ(req), .ADDR(addr), .HOLD(hold),
    .GNT(gnt1), .RSEL(rsel1), .RDATA_IN(rdata_in1),
    .WE(we), .WADDR(waddr), .WDATA(wdata),
    .RVALID(rvalid1), .RDATA(rdata1)
  );

  task automatic test_reset();
    rst = 1'b1; req = 4'b1111; addr = 16'h3210;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++; if (gnt0 !== 4'b0000 || gnt1 !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b/%b want 0000", gnt0, gnt1); end
      checks++; if (rsel0 !== 4'h0) begin errors++; $display("FAIL reset_rsel: got %h want 0", rsel0); end
      @(posedge clk); #1;
      checks++; if (rvalid0 !== 4'b0000 || rvalid1 !== 4'b0000) begin errors++; $display("FAIL reset_rvalid: got %b/%b want 0000", rvalid0, rvalid1); end
      checks++; if (rdata0 !== 16'h0000 || rdata1 !== 16'h0000) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0000", rdata0, rdata1); end
    end
    @(negedge clk); rst = 1'b0; #1;
    checks++; if (gnt0 !== 4'b0001 || gnt1 !== 4'b0001) begin errors++; $display("FAIL reset_first_gnt: got %b/%b want 0001", gnt0, gnt1); end
    @(posedge clk); #1;
    checks++; if (rvalid0 !== 4'b0001 || rdata0 !== 16'hA000) begin errors++; $display("FAIL reset_first_rd: got %b %h want 0001 a000", rvalid0, rdata0); end
    @(negedge clk); req = 4'b0000;
  endtask

  // Pointer is 1 on entry
  task automatic test_single();
    req = 4'b0100; addr = 16'h0900; #1;
    checks++; if (gnt0 !== 4'b0100 || rsel0 !== 4'h9) begin errors++; $display("FAIL single_gnt: got %b rsel %h want 0100 rsel 9", gnt0, rsel0); end
    @(posedge clk); #1;
    checks++; if (rvalid0 !== 4'b0100 || rdata0 !== 16'hBEEF) begin errors++; $display("FAIL single_rd: got %b %h want 0100 beef", rvalid0, rdata0); end
    @(negedge clk); req = 4'b0000; #1;
    checks++; if (gnt0 !== 4'b0000 || rsel0 !== 4'h0) begin errors++; $display("FAIL idle_gnt: got %b rsel %h want 0000 rsel 0", gnt0, rsel0); end
    @(posedge clk); #1;
    checks++; if (rvalid0 !== 4'b0000 || rdata0 !== 16'hBEEF) begin errors++; $display("FAIL idle_hold_rd: got %b %h want 0000 beef", rvalid0, rdata0); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] eg;
    @(negedge clk); rst = 1'b1; req = 4'b1111; addr = 16'h7654;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      eg = 4'b0001 << (k % 4);
      #1;
      checks++; if (gnt0 !== eg || rsel0 !== 4'(4 + k % 4)) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b rsel %h want %b rsel %h", k, gnt0, rsel0, eg, 4'(4 + k % 4)); end
      @(posedge clk); #1;
      checks++; if (rvalid0 !== eg || rdata0 !== 16'hA004 + 16'(k % 4)) begin errors++; $display("FAIL b2b_rd[%0d]: got %b %h want %b %h", k, rvalid0, rdata0, eg, 16'hA004 + 16'(k % 4)); end
      @(negedge clk);
    end
    req = 4'b0000;
  endtask

  // Pointer is 0 on entry
  task automatic test_ptr_skip();
    @(negedge clk); req = 4'b0001; addr = 16'h9000; #1;
    checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL skip_pre: got %b want 0001", gnt0); end
    @(negedge clk); req = 4'b1001; #1;
    checks++; if (gnt0 !== 4'b1000 || rsel0 !== 4'h9) begin errors++; $display("FAIL skip_gnt3: got %b rsel %h want 1000 rsel 9", gnt0, rsel0); end
    @(negedge clk); #1;
    checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL skip_wrap0: got %b want 0001", gnt0); end
    @(posedge clk); #1;
    checks++; if (rvalid0 !== 4'b0001 || rdata0 !== 16'hA000) begin errors++; $display("FAIL skip_rd: got %b %h want 0001 a000", rvalid0, rdata0); end
    @(negedge clk); req = 4'b1010; #1;
    checks++; if (gnt0 !== 4'b0010) begin errors++; $display("FAIL skip_ptr1: got %b want 0010", gnt0); end
    @(negedge clk); req = 4'b0000;
  endtask

  // Pointer is 2 on entry; requester 0 reads register 3 three times
  task automatic test_bypass();
    req = 4'b0001; addr = 16'h0003; we = 1'b1; waddr = 4'h4; wdata = 16'h5555; #1;
    checks++; if (gnt0 !== 4'b0001 || rsel0 !== 4'h3) begin errors++; $display("FAIL byp_gnt: got %b rsel %h want 0001 rsel 3", gnt0, rsel0); end
    @(posedge clk); #1;
    checks++; if (rdata0 !== 16'h0000 || rdata1 !== 16'h0000) begin errors++; $display("FAIL byp_nomatch: got %h/%h want 0000/0000", rdata0, rdata1); end
    @(negedge clk); waddr = 4'h3; wdata = 16'h1234;
    @(posedge clk); #1;
    checks++; if (rdata0 !== 16'h1234) begin errors++; $display("FAIL byp_fwd: got %h want 1234", rdata0); end
    checks++; if (rdata1 !== 16'h0000) begin errors++; $display("FAIL byp_off_old: got %h want 0000", rdata1); end
    @(negedge clk); we = 1'b0;
    @(posedge clk); #1;
    checks++; if (rdata0 !== 16'h1234 || rdata1 !== 16'h1234 || rvalid1 !== 4'b0001) begin errors++; $display("FAIL byp_after: got %h/%h %b want 1234/1234 0001", rdata0, rdata1, rvalid1); end
  endtask

  // Pointer is 1 on entry
  task automatic test_hold();
    @(negedge clk); hold = 1'b1; req = 4'b0010; addr = 16'h0050;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (c == 0) begin
        checks++; if (rvalid0 !== 4'b0001) begin errors++; $display("FAIL hold_prev_rvalid: got %b want 0001", rvalid0); end
      end
      checks++; if (gnt0 !== 4'b0000 || rsel0 !== 4'h0) begin errors++; $display("FAIL hold_gnt[%0d]: got %b rsel %h want 0000 rsel 0", c, gnt0, rsel0); end
      @(posedge clk); #1;
      checks++; if (rvalid0 !== 4'b0000) begin errors++; $display("FAIL hold_rvalid[%0d]: got %b want 0000", c, rvalid0); end
      @(negedge clk);
    end
    hold = 1'b0; req = 4'b0011; #1;
    checks++; if (gnt0 !== 4'b0010 || rsel0 !== 4'h5) begin errors++; $display("FAIL hold_release: got %b rsel %h want 0010 rsel 5", gnt0, rsel0); end
    @(posedge clk); #1;
    checks++; if (rvalid0 !== 4'b0010 || rdata0 !== 16'hA005) begin errors++; $display("FAIL hold_rd: got %b %h want 0010 a005", rvalid0, rdata0); end
  endtask

  // Pointer is 2 on entry
  task automatic test_mid_reset();
    @(negedge clk); req = 4'b0100; addr = 16'h0900; rst = 1'b1; #1;
    checks++; if (gnt0 !== 4'b0000) begin errors++; $display("FAIL midrst_gnt: got %b want 0000", gnt0); end
    @(posedge clk); #1;
    checks++; if (rvalid0 !== 4'b0000 || rvalid1 !== 4'b0000 || rdata0 !== 16'h0000) begin errors++; $display("FAIL midrst_rd: got %b/%b %h want 0000/0000 0000", rvalid0, rvalid1, rdata0); end
    @(negedge clk); rst = 1'b0; req = 4'b0101; #1;
    checks++; if (gnt0 !== 4'b0001) begin errors++; $display("FAIL midrst_ptr: got %b want 0001", gnt0); end
    @(negedge clk); req = 4'b0000;
  endtask

  initial begin
    rst = 1'b1; req = '0; addr = '0; hold = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_ptr_skip();
    test_bypass();
    test_hold();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
